aer_uart_tx_bridge: RTL and testbench

// Next-generation AER-output-to-UART egress bridge between the tinyODIN AEROUT port and the uart TX AXI-Stream input.
// - Completes the AER 4-phase handshake with the core.
// - Buffers output events in a FIFO.
// - Serialises each event into a framed byte packet: optional header, little-endian address, optional timestamp.
// - Generalises the direct AEROUT-to-tdata tie-off: wide addresses, event buffering, full-FIFO policy, timestamping.

---
 rtl/aer_bridge_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/aer_uart_tx_bridge.sv | 170 +++++++++++++++++
 tb/tb_aer_uart_tx_bridge.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aer_bridge_pkg.sv
// Shared definitions for the AER-to-UART egress bridge: FSM encodings, default header, byte-count helpers.
// No logic; latency and backpressure are properties of the modules that import this package.
package aer_bridge_pkg;

    typedef enum logic [1:0] {
        AER_BRIDGE_ST_IDLE = 2'd0,
        AER_BRIDGE_ST_HDR  = 2'd1,
        AER_BRIDGE_ST_ADDR = 2'd2,
        AER_BRIDGE_ST_TS   = 2'd3
    } aer_bridge_st_e;

    localparam logic [7:0] AER_BRIDGE_HDR_BYTE = 8'hFF;

    function automatic int addr_bytes(input int addr_w);
        return (addr_w + 7) / 8;
    endfunction

    function automatic int ts_bytes(input int ts_en, input int ts_w);
        return (ts_en != 0) ? ts_w / 8 : 0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read: data appears on rd_dat_o the cycle after a pop.
// Pushes while full and pops while empty are ignored; the caller owns any backpressure.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wr_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [LW-1:0]    level_q;
    logic [WIDTH-1:0] rd_q;
    logic             do_push, do_pop;

    assign full_o   = (level_q == LW'(DEPTH));
    assign empty_o  = (level_q == '0);
    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign rd_dat_o = rd_q;
    assign level_o  = level_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wr_dat_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            rd_q    <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop) begin
                rd_q   <= mem_q[rptr_q];
                rptr_q <= rptr_q + AW'(1);
            end
            if (do_push && !do_pop)      level_q <= level_q + LW'(1);
            else if (do_pop && !do_push) level_q <= level_q - LW'(1);
        end
    end

endmodule

// File: rtl/aer_uart_tx_bridge.sv
// AER 4-phase egress to AXI-Stream byte packets {hdr, addr LE, ts LE}; first byte valid 1 cycle after pop.
// tready stalls hold the byte; a full FIFO either drops-and-ACKs or withholds ACK.
module aer_uart_tx_bridge
    import aer_bridge_pkg::*;
#(
    parameter int         ADDR_W       = 8,
    parameter int         DEPTH        = 16,
    parameter int         TS_EN        = 0,
    parameter int         TS_W         = 16,
    parameter int         TS_PRESCALE  = 1000,
    parameter int         HDR_EN       = 0,
    parameter logic [7:0] HDR_BYTE     = AER_BRIDGE_HDR_BYTE,
    parameter int         DROP_ON_FULL = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      aer_addr,
    input  logic                   aer_req,
    output logic                   aer_ack,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [15:0]            overflow_cnt,
    input  logic                   clr_overflow
);
    localparam int AB = addr_bytes(ADDR_W);
    localparam int TB = ts_bytes(TS_EN, TS_W);
    localparam int DW = ADDR_W + TS_W * TS_EN;

    logic              fifo_full, fifo_empty, fifo_pop;
    logic              accept, drop, beat, pkt_done, last_addr, last_ts;
    logic [DW-1:0]     push_dat, rd_dat;
    logic [TS_W-1:0]   ts_word;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        addr_byte, ts_byte;
    logic              ack_q, ack_d;
    logic [15:0]       ovf_q, ovf_d;
    logic [2:0]        idx_q, idx_d;
    aer_bridge_st_e    state_q, state_d, first_st;

    generate
        if (TS_EN != 0) begin : g_ts
            localparam int PW = (TS_PRESCALE > 1) ? $clog2(TS_PRESCALE) : 1;
            logic [PW-1:0]   pre_q;
            logic [TS_W-1:0] ts_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pre_q <= '0;
                    ts_q  <= '0;
                end else if (pre_q == PW'(TS_PRESCALE - 1)) begin
                    pre_q <= '0;
                    ts_q  <= ts_q + TS_W'(1);
                end else begin
                    pre_q <= pre_q + PW'(1);
                end
            end

            assign push_dat = {ts_q, aer_addr};
            assign ts_word  = rd_dat[DW-1 -: TS_W];
        end else begin : g_no_ts
            assign push_dat = aer_addr;
            assign ts_word  = '0;
        end
    endgenerate

    sync_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (accept),
        .wr_dat_i (push_dat),
        .pop_i    (fifo_pop),
        .rd_dat_o (rd_dat),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .level_o  (fifo_level)
    );

    // Full flag is pre-pop: a slot freed this cycle is usable only next cycle.
    assign accept = aer_req && !ack_q && !fifo_full;
    assign drop   = aer_req && !ack_q && fifo_full && (DROP_ON_FULL != 0);
    assign ack_d  = ack_q ? aer_req : (accept || drop);

    always_comb begin
        ovf_d = ovf_q;
        if (clr_overflow)                 ovf_d = '0;
        else if (drop && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
    end

    // The FIFO read register doubles as the packet holding register.
    assign rd_addr       = rd_dat[ADDR_W-1:0];
    assign addr_byte     = 8'(rd_addr >> {idx_q, 3'b000});
    assign ts_byte       = 8'(ts_word >> {idx_q, 3'b000});
    assign last_addr     = (idx_q == 3'(AB - 1));
    assign last_ts       = (idx_q == 3'(TB - 1));
    assign first_st      = (HDR_EN != 0) ? AER_BRIDGE_ST_HDR : AER_BRIDGE_ST_ADDR;
    assign m_axis_tvalid = (state_q != AER_BRIDGE_ST_IDLE);
    assign beat          = m_axis_tvalid && m_axis_tready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fifo_pop     = 1'b0;
        pkt_done     = 1'b0;
        m_axis_tdata = '0;
        m_axis_tlast = 1'b0;
        case (state_q)
            AER_BRIDGE_ST_HDR: begin
                m_axis_tdata = HDR_BYTE;
                if (beat) begin
                    state_d = AER_BRIDGE_ST_ADDR;
                    idx_d   = '0;
                end
            end
            AER_BRIDGE_ST_ADDR: begin
                m_axis_tdata = addr_byte;
                m_axis_tlast = last_addr && (TB == 0);
                if (beat) begin
                    if (!last_addr) begin
                        idx_d = idx_q + 3'd1;
                    end else if (TB != 0) begin
                        state_d = AER_BRIDGE_ST_TS;
                        idx_d   = '0;
                    end else begin
                        pkt_done = 1'b1;
                    end
                end
            end
            AER_BRIDGE_ST_TS: begin
                m_axis_tdata = ts_byte;
                m_axis_tlast = last_ts;
                if (beat) begin
                    if (!last_ts) idx_d = idx_q + 3'd1;
                    else          pkt_done = 1'b1;
                end
            end
            default: ;
        endcase
        // Pop on the last beat too, so packets run back-to-back.
        if (state_q == AER_BRIDGE_ST_IDLE || pkt_done) begin
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                state_d  = first_st;
                idx_d    = '0;
            end else if (pkt_done) begin
                state_d = AER_BRIDGE_ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= AER_BRIDGE_ST_IDLE;
            idx_q   <= '0;
            ack_q   <= 1'b0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
        end
    end

    assign aer_ack      = ack_q;
    assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_aer_uart_tx_bridge.sv
// Directed bench: instance A (10-bit addr, no hdr/ts, stall on full), instance B (hdr+ts, drop on full).
module tb_aer_uart_tx_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  addr_a;
    logic        req_a, ack_a, tvalid_a, tready_a, tlast_a, clr_a;
    logic [7:0]  tdata_a;
    logic [2:0]  level_a;
    logic [15:0] ovf_a;
    logic [7:0]  addr_b;
    logic        req_b, ack_b, tvalid_b, tready_b, tlast_b, clr_b;
    logic [7:0]  tdata_b;
    logic [2:0]  level_b;
    logic [15:0] ovf_b;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    logic [8:0]  mon_a[$], mon_b[$];
    logic [8:0]  held_a, held_b;
    logic        stall_a, stall_b;
    logic [15:0] tb_cyc;

    always #5 clk = ~clk;

    aer_uart_tx_bridge #(
        .ADDR_W(10), .DEPTH(4), .TS_EN(0), .TS_W(16), .TS_PRESCALE(1),
        .HDR_EN(0), .HDR_BYTE(8'hFF), .DROP_ON_FULL(0)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .aer_addr(addr_a), .aer_req(req_a), .aer_ack(ack_a),
        .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a),
        .m_axis_tlast(tlast_a), .fifo_level(level_a), .overflow_cnt(ovf_a), .clr_overflow(clr_a)
    );

    aer_uart_tx_bridge #(
        .ADDR_W(8), .DEPTH(4), .TS_EN(1), .TS_W(16), .TS_PRESCALE(1),
        .HDR_EN(1), .HDR_BYTE(8'hFF), .DROP_ON_FULL(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .aer_addr(addr_b), .aer_req(req_b), .aer_ack(ack_b),
        .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b),
        .m_axis_tlast(tlast_b), .fifo_level(level_b), .overflow_cnt(ovf_b), .clr_overflow(clr_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Elapsed cycles since reset release; equals the timestamp when TS_PRESCALE=1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 16'd1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_a <= 1'b0;
            stall_b <= 1'b0;
        end else begin
            if (stall_a) check("stable_a", {tvalid_a, tlast_a, tdata_a}, {1'b1, held_a});
            if (stall_b) check("stable_b", {tvalid_b, tlast_b, tdata_b}, {1'b1, held_b});
            if (tvalid_a && tready_a) mon_a.push_back({tlast_a, tdata_a});
            if (tvalid_b && tready_b) mon_b.push_back({tlast_b, tdata_b});
            stall_a <= tvalid_a && !tready_a;
            stall_b <= tvalid_b && !tready_b;
            held_a  <= {tlast_a, tdata_a};
            held_b  <= {tlast_b, tdata_b};
        end
    end

    task automatic send_a(input logic [9:0] a, input string tag);
        int w;
        addr_a = a;
        req_a  = 1'b1;
        w = 0;
        while (!ack_a && w < 300) begin tick(1); w++; end
        check({tag, "_ack_rise"}, ack_a, 1);
        req_a = 1'b0;
        w = 0;
        while (ack_a && w < 300) begin tick(1); w++; end
        check({tag, "_ack_fall"}, ack_a, 0);
    endtask

    task automatic send_b(input logic [7:0] a, input string tag);
        int w;
        addr_b = a;
        req_b  = 1'b1;
        w = 0;
        while (!ack_b && w < 300) begin tick(1); w++; end
        check({tag, "_ack_rise"}, ack_b, 1);
        req_b = 1'b0;
        w = 0;
        while (ack_b && w < 300) begin tick(1); w++; end
        check({tag, "_ack_fall"}, ack_b, 0);
    endtask

    task automatic wait_mon(input int which, input int n, input string tag);
        int w = 0;
        while (((which == 0) ? mon_a.size() : mon_b.size()) < n && w < 3000) begin
            tick(1);
            w++;
        end
        check(tag, (which == 0) ? mon_a.size() : mon_b.size(), n);
    endtask

    initial begin
        logic [9:0]  t4_addr [6];
        logic [9:0]  exp_q[$];
        logic [9:0]  ea;
        logic [15:0] exp_ts;
        logic        ack_seen;
        logic        prod_done;
        int          w;

        rst_n = 1'b0;
        addr_a = '0; req_a = 1'b0; tready_a = 1'b0; clr_a = 1'b0;
        addr_b = '0; req_b = 1'b0; tready_b = 1'b0; clr_b = 1'b0;
        #1;
        check("reset_a", {ack_a, tvalid_a, tlast_a, tdata_a, level_a, ovf_a}, 0);
        check("reset_b", {ack_b, tvalid_b, tlast_b, tdata_b, level_b, ovf_b}, 0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // 10-bit address splits into two bytes; ack follows the 4-phase handshake exactly.
        tready_a = 1'b1;
        addr_a = 10'h2A5;
        req_a  = 1'b1;
        tick(1);
        check("t1_ack_next_cycle", ack_a, 1);
        check("t1_level_after_push", level_a, 1);
        req_a = 1'b0;
        tick(1);
        check("t1_ack_drop", ack_a, 0);
        wait_mon(0, 2, "t1_byte_count");
        check("t1_bytes", {mon_a[0], mon_a[1]}, {9'h0A5, 9'h102});

        // Header + timestamp packet with the counter at 0x1234 in the push cycle.
        tready_b = 1'b1;
        w = 0;
        while (tb_cyc != 16'h1234 && w < 70000) begin tick(1); w++; end
        check("t2_reach_ts", tb_cyc, 16'h1234);
        send_b(8'h3C, "t2");
        wait_mon(1, 4, "t2_byte_count");
        check("t2_hdr_addr", {mon_b[0], mon_b[1]}, {9'h0FF, 9'h03C});
        check("t2_ts", {mon_b[2], mon_b[3]}, {9'h034, 9'h112});

        // Drop-on-full: one event sits in the serialiser, four fill the FIFO, the sixth is dropped.
        mon_b.delete();
        tready_b = 1'b0;
        for (int i = 0; i < 6; i++) send_b(8'h10 + 8'(i), "t3");
        tick(2);
        check("t3_level_full", level_b, 4);
        check("t3_overflow", ovf_b, 1);
        check("t3_stalled_hdr", {tvalid_b, tdata_b}, 9'h1FF);
        tready_b = 1'b1;
        wait_mon(1, 20, "t3_bytes");
        tick(10);
        check("t3_exact_bytes", mon_b.size(), 20);
        for (int k = 0; k < 5; k++)
            check("t3_packet", {mon_b[4*k], mon_b[4*k+1], mon_b[4*k+2][8], mon_b[4*k+3][8]},
                  {9'h0FF, 1'b0, 8'h10 + 8'(k), 1'b0, 1'b1});
        check("t3_level_empty", level_b, 0);
        clr_b = 1'b1;
        tick(1);
        clr_b = 1'b0;
        check("t3_clr_overflow", ovf_b, 0);

        // Stall-on-full: ack withheld until the held packet drains and a slot frees.
        mon_a.delete();
        tready_a = 1'b0;
        t4_addr = '{10'h100, 10'h101, 10'h102, 10'h103, 10'h104, 10'h3FF};
        for (int i = 0; i < 5; i++) send_a(t4_addr[i], "t4");
        check("t4_level_full", level_a, 4);
        addr_a = 10'h3FF;
        req_a  = 1'b1;
        ack_seen = 1'b0;
        repeat (5) begin
            tick(1);
            if (ack_a) ack_seen = 1'b1;
        end
        check("t4_ack_held", ack_seen, 0);
        check("t4_no_overflow", ovf_a, 0);
        tready_a = 1'b1;
        tick(2);
        check("t4_deferred_on_pop", ack_a, 0);
        tick(1);
        check("t4_accept_next_slot", ack_a, 1);
        check("t4_level_refill", level_a, 4);
        req_a = 1'b0;
        w = 0;
        while (ack_a && w < 300) begin tick(1); w++; end
        check("t4_ack_fall", ack_a, 0);
        wait_mon(0, 12, "t4_bytes");
        for (int k = 0; k < 6; k++) begin
            ea = t4_addr[k];
            check("t4_packet", {mon_a[2*k], mon_a[2*k+1]}, {1'b0, ea[7:0], 1'b1, 6'b0, ea[9:8]});
        end
        check("t4_overflow_zero", ovf_a, 0);

        // Random tready stalls against a queue of sent addresses.
        mon_a.delete();
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    ea = 10'($urandom);
                    exp_q.push_back(ea);
                    send_a(ea, "t5");
                end
                prod_done = 1'b1;
            end
            begin
                for (int c = 0; c < 30000 && !(prod_done && mon_a.size() >= 400); c++) begin
                    tready_a = 1'($urandom_range(0, 1));
                    tick(1);
                end
                tready_a = 1'b1;
            end
        join
        tick(5);
        check("t5_byte_count", mon_a.size(), 400);
        for (int k = 0; k < 200; k++) begin
            ea = exp_q[k];
            check("t5_packet", {mon_a[2*k], mon_a[2*k+1]}, {1'b0, ea[7:0], 1'b1, 6'b0, ea[9:8]});
        end

        // Reset after the first of four bytes: partial packet is discarded.
        mon_b.delete();
        tready_b = 1'b0;
        send_b(8'hA7, "t6");
        check("t6_pending_hdr", {tvalid_b, tdata_b}, 9'h1FF);
        tready_b = 1'b1;
        tick(1);
        tready_b = 1'b0;
        check("t6_pending_addr", {tvalid_b, tdata_b}, 9'h1A7);
        rst_n = 1'b0;
        #1;
        check("t6_reset_outputs", {ack_b, tvalid_b, tlast_b, tdata_b, level_b, ovf_b}, 0);
        tick(2);
        rst_n = 1'b1;
        mon_b.delete();
        tick(5);
        tready_b = 1'b1;
        exp_ts = tb_cyc;
        send_b(8'h5E, "t6_post");
        wait_mon(1, 4, "t6_byte_count");
        check("t6_hdr_addr", {mon_b[0], mon_b[1]}, {9'h0FF, 9'h05E});
        check("t6_ts", {mon_b[2], mon_b[3]}, {1'b0, exp_ts[7:0], 1'b1, exp_ts[15:8]});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
